// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

  // Control states of the serial subtractor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bit counter width: must hold WIDTH-1 with one spare bit so it never wraps.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow-out bo.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: D = A - B - bin, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_s;
  logic             last_bit_s;
  logic             cell_d_s;
  logic             cell_bo_s;
  logic [WIDTH-1:0] res_shift_s;

  // The single arithmetic cell, fed by the operand LSBs and the borrow flop.
  full_subtractor u_cell (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .bi (br_q),
    .d  (cell_d_s),
    .bo (cell_bo_s)
  );

  // in_ready_q is low during reset and in its first edge, so gating on it
  // keeps reset-overlapping handshakes from being captured.
  assign accept_s   = (state_q == IDLE) & in_valid & in_ready_q;
  assign last_bit_s = (state_q == SHIFT) & (cnt_q == LAST);

  // Result register shifted right with the new difference bit entering at the MSB.
  always_comb begin
    res_shift_s            = res_q >> 1'b1;
    res_shift_s[WIDTH-1]   = cell_d_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_bit_s) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and handshake next values; results change only on the last bit.
  always_comb begin
    sa_d        = sa_q;
    sb_d        = sb_q;
    res_d       = res_q;
    diff_d      = diff_q;
    cnt_d       = cnt_q;
    br_d        = br_q;
    a_msb_d     = a_msb_q;
    b_msb_d     = b_msb_q;
    bout_d      = bout_q;
    ovf_d       = ovf_q;
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          sa_d    = a;
          sb_d    = b;
          br_d    = bin;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      SHIFT: begin
        sa_d  = sa_q >> 1'b1;
        sb_d  = sb_q >> 1'b1;
        res_d = res_shift_s;
        br_d  = cell_bo_s;
        cnt_d = cnt_q + CW'(1);
        if (last_bit_s) begin
          diff_d = res_shift_s;
          bout_d = cell_bo_s;
          ovf_d  = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d_s);
        end else begin
          diff_d = diff_q;
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q        <= '0;
      sb_q        <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      br_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      res_q       <= res_d;
      diff_q      <= diff_d;
      cnt_q       <= cnt_d;
      br_q        <= br_d;
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      bout_q      <= bout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
